// File: rtl/x_adc_frame_assembler_if.sv
// ---------------------------------------------------------------------------
// x_adc_frame_assembler_if
// Bundles the sample stream from the acquisition front end with the published
// frame bus that goes to the frame-capture register bank.
//   sample_in / sample_valid / sample_sof : per-cycle ADC sample, channel 0 tagged
//   srdyi                                 : one-cycle "new frame" strobe
//   x_adc[0..NUM_CH-1]                    : published frame (x_adc_0..x_adc_31)
//   busy / frame_err / err_count          : assembler status
// master = sample producer / frame consumer, slave = the assembler.
// ---------------------------------------------------------------------------
interface x_adc_frame_assembler_if #(
  parameter int DATA_W = 21,
  parameter int NUM_CH = 32
);
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              sample_sof;
  logic              srdyi;
  logic [DATA_W-1:0] x_adc [NUM_CH];
  logic              busy;
  logic              frame_err;
  logic [7:0]        err_count;

  modport master (
    output sample_in, sample_valid, sample_sof,
    input  srdyi, x_adc, busy, frame_err, err_count
  );

  modport slave (
    input  sample_in, sample_valid, sample_sof,
    output srdyi, x_adc, busy, frame_err, err_count
  );
endinterface

// File: rtl/x_adc_frame_assembler.sv
// ---------------------------------------------------------------------------
// x_adc_frame_assembler
// Collects one ADC sample per cycle into a shadow buffer and publishes each
// complete NUM_CH-channel frame on frm.x_adc with a one-cycle frm.srdyi pulse.
// Malformed frames (orphan sample, early start-of-frame, stall timeout) raise
// a one-cycle frm.frame_err and bump the saturating frm.err_count.
// Ports:
//   clk          : rising-edge clock
//   GlobalReset  : synchronous reset, active high
//   frm (slave)  : sample input stream, published frame and status outputs
// ---------------------------------------------------------------------------
module x_adc_frame_assembler #(
  parameter int DATA_W       = 21,
  parameter int NUM_CH       = 32,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    GlobalReset,
  x_adc_frame_assembler_if.slave  frm
);

  localparam int            CW        = $clog2(NUM_CH);
  localparam int            IW        = $clog2(IDLE_TIMEOUT);
  localparam logic [CW-1:0] LAST_CH   = CW'(NUM_CH - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_ch_cnt;
  logic [IW-1:0]     r_idle_cnt;
  // The last channel goes straight from sample_in to the output, so the
  // shadow only needs to hold channels 0..NUM_CH-2.
  logic [DATA_W-1:0] r_shadow [NUM_CH-1];
  logic [DATA_W-1:0] r_x_adc  [NUM_CH];
  logic              r_srdyi;
  logic              r_busy;
  logic              r_frame_err;
  logic [7:0]        r_err_count;

  logic              w_accept;
  logic              w_sof;
  logic              w_err;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_accept = frm.sample_valid;
  assign w_sof    = frm.sample_valid & frm.sample_sof;

  // All three error sources are mutually exclusive, so one edge never carries
  // more than one error.
  always_comb begin
    w_err = 1'b0;
    case (r_state)
      S_IDLE: w_err = w_accept & ~frm.sample_sof;
      S_FILL: w_err = w_sof | (~w_accept & (r_idle_cnt == IDLE_LAST));
      default: w_err = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      r_state     <= S_IDLE;
      r_ch_cnt    <= '0;
      r_idle_cnt  <= '0;
      r_srdyi     <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_count <= '0;
      for (int c = 0; c < NUM_CH - 1; c++) r_shadow[c] <= '0;
      for (int c = 0; c < NUM_CH; c++)     r_x_adc[c]  <= '0;
    end else begin
      r_srdyi     <= 1'b0;
      r_frame_err <= w_err;
      if (w_err) r_err_count <= sat_inc(r_err_count);

      case (r_state)
        S_IDLE: begin
          if (w_sof) begin
            r_shadow[0] <= frm.sample_in;
            r_ch_cnt    <= CW'(1);
            r_idle_cnt  <= '0;
            r_state     <= S_FILL;
            r_busy      <= 1'b1;
          end
        end

        S_FILL: begin
          if (w_sof) begin
            // Early SOF wins over completion: restart with this as channel 0.
            r_shadow[0] <= frm.sample_in;
            r_ch_cnt    <= CW'(1);
            r_idle_cnt  <= '0;
          end else if (w_accept && (r_ch_cnt == LAST_CH)) begin
            for (int c = 0; c < NUM_CH - 1; c++) r_x_adc[c] <= r_shadow[c];
            r_x_adc[NUM_CH-1] <= frm.sample_in;
            r_srdyi    <= 1'b1;
            r_ch_cnt   <= '0;
            r_idle_cnt <= '0;
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
          end else if (w_accept) begin
            r_shadow[r_ch_cnt] <= frm.sample_in;
            r_ch_cnt           <= r_ch_cnt + CW'(1);
            r_idle_cnt         <= '0;
          end else if (r_idle_cnt == IDLE_LAST) begin
            // Stall timeout: drop the partial frame, published data untouched.
            r_ch_cnt   <= '0;
            r_idle_cnt <= '0;
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
          end else begin
            r_idle_cnt <= r_idle_cnt + IW'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign frm.srdyi     = r_srdyi;
  assign frm.busy      = r_busy;
  assign frm.frame_err = r_frame_err;
  assign frm.err_count = r_err_count;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign frm.x_adc[g] = r_x_adc[g];
  end

endmodule

// File: tb/tb_x_adc_frame_assembler.sv
// ---------------------------------------------------------------------------
// tb_x_adc_frame_assembler
// Table of frame scenarios plus hand-written sequences for back-to-back
// frames, reset mid-frame and error-counter saturation. Expected frames are
// queued when stimulus is driven and compared when srdyi is observed; between
// publishes the outputs are checked to hold the last published frame.
// ---------------------------------------------------------------------------
module tb_x_adc_frame_assembler;
  localparam int DATA_W       = 21;
  localparam int NUM_CH       = 32;
  localparam int IDLE_TIMEOUT = 64;

  typedef logic [NUM_CH-1:0][DATA_W-1:0] frame_t;
  typedef enum int {K_NONE, K_SOF, K_STALL, K_ORPHAN} kind_t;
  typedef struct {
    logic [DATA_W-1:0] base;
    bit                dec;
    int                gap;
    kind_t             kind;
    int                cut;
    int                stall;
    int                exp_pub;
    int                exp_err;
    int                exp_busy;
  } vec_t;

  logic clk = 1'b0;
  logic GlobalReset = 1'b1;
  always #5 clk = ~clk;

  x_adc_frame_assembler_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) frm ();

  x_adc_frame_assembler #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .clk(clk), .GlobalReset(GlobalReset), .frm(frm)
  );

  int     checks = 0;
  int     errors = 0;
  frame_t exp_q[$];
  frame_t cur_pub = '0;
  int     n_srdyi = 0, n_err = 0, n_busy = 0;
  int     cyc = 0, last_srdyi_cyc = -1, srdyi_gap = 0;
  logic   prev_srdyi = 1'b0;
  int     exp_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_frame(input string name, input frame_t e);
    int bad;
    bad = -1;
    for (int c = 0; c < NUM_CH; c++)
      if (frm.x_adc[c] !== e[c] && bad < 0) bad = c;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s ch%0d: got %h expected %h", name, bad, frm.x_adc[bad], e[bad]);
    end
  endtask

  function automatic logic [DATA_W-1:0] gen(input logic [DATA_W-1:0] base, input bit dec, input int i);
    return dec ? base - DATA_W'(i) : base + DATA_W'(i);
  endfunction

  function automatic frame_t mk_frame(input logic [DATA_W-1:0] base, input bit dec);
    frame_t f;
    for (int i = 0; i < NUM_CH; i++) f[i] = gen(base, dec, i);
    return f;
  endfunction

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (GlobalReset) begin
      exp_q.delete();
      cur_pub    = '0;
      prev_srdyi = 1'b0;
    end else begin
      if (frm.busy === 1'b1)      n_busy++;
      if (frm.frame_err === 1'b1) n_err++;
      if (frm.srdyi === 1'b1) begin
        n_srdyi++;
        chk("srdyi_width", {63'd0, prev_srdyi}, 64'd0);
        if (last_srdyi_cyc >= 0) srdyi_gap = cyc - last_srdyi_cyc;
        last_srdyi_cyc = cyc;
        if (exp_q.size() == 0) chk("unexpected_srdyi", 64'd1, 64'd0);
        else begin
          cur_pub = exp_q.pop_front();
          cmp_frame("publish_data", cur_pub);
        end
      end else begin
        cmp_frame("hold_data", cur_pub);
      end
      prev_srdyi = frm.srdyi;
    end
  end

  task automatic send(input logic [DATA_W-1:0] d, input logic sof);
    frm.sample_in    = d;
    frm.sample_valid = 1'b1;
    frm.sample_sof   = sof;
    @(posedge clk); #1;
    frm.sample_valid = 1'b0;
    frm.sample_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic add_err(input int n);
    exp_cnt = exp_cnt + n;
    if (exp_cnt > 255) exp_cnt = 255;
  endtask

  vec_t tv [7];

  initial begin
    int  s0, e0;
    bit  aborted;
    vec_t v;

    tv[0] = '{21'h01000,  1'b0, 0, K_NONE,   -1,  0, 1, 0, 31};
    tv[1] = '{21'h1FFFFF, 1'b1, 2, K_NONE,   -1,  0, 1, 0, 93};
    tv[2] = '{21'h00500,  1'b0, 0, K_SOF,    10,  0, 1, 1, -1};
    tv[3] = '{21'h0A000,  1'b0, 0, K_SOF,    31,  0, 1, 1, -1};
    tv[4] = '{21'h0B000,  1'b0, 0, K_STALL,   6, 64, 0, 1, 69};
    tv[5] = '{21'h0C000,  1'b0, 0, K_ORPHAN, -1,  0, 0, 1,  0};
    tv[6] = '{21'h0D000,  1'b0, 0, K_STALL,   6, 63, 1, 0, 94};

    frm.sample_in    = '0;
    frm.sample_valid = 1'b0;
    frm.sample_sof   = 1'b0;
    repeat (3) @(posedge clk);
    #1 GlobalReset = 1'b0;

    @(negedge clk);
    chk("rst_srdyi",     {63'd0, frm.srdyi},     64'd0);
    chk("rst_busy",      {63'd0, frm.busy},      64'd0);
    chk("rst_frame_err", {63'd0, frm.frame_err}, 64'd0);
    chk("rst_err_count", {56'd0, frm.err_count}, 64'd0);
    cmp_frame("rst_x_adc", '0);

    for (int k = 0; k < 7; k++) begin
      v      = tv[k];
      s0     = n_srdyi;
      e0     = n_err;
      n_busy = 0;
      if (v.kind == K_ORPHAN) begin
        send(v.base, 1'b0);
      end else begin
        aborted = 1'b0;
        if (v.kind == K_NONE || (v.kind == K_STALL && v.stall < IDLE_TIMEOUT))
          exp_q.push_back(mk_frame(v.base, v.dec));
        for (int i = 0; i < NUM_CH && !aborted; i++) begin
          if (v.kind == K_SOF && i == v.cut) aborted = 1'b1;
          else begin
            if (v.kind == K_STALL && i == v.cut) begin
              idle(v.stall);
              if (v.stall >= IDLE_TIMEOUT) aborted = 1'b1;
            end
            if (!aborted) begin
              send(gen(v.base, v.dec, i), i == 0);
              idle(v.gap);
            end
          end
        end
        if (v.kind == K_SOF) begin
          exp_q.push_back(mk_frame(v.base + 21'h100, v.dec));
          for (int i = 0; i < NUM_CH; i++) send(gen(v.base + 21'h100, v.dec, i), i == 0);
        end
      end
      idle(4);
      add_err(v.exp_err);
      chk($sformatf("v%0d_srdyi_count", k), 64'(n_srdyi - s0), 64'(v.exp_pub));
      chk($sformatf("v%0d_err_pulses", k),  64'(n_err - e0),   64'(v.exp_err));
      chk($sformatf("v%0d_err_count", k),   {56'd0, frm.err_count}, 64'(exp_cnt));
      chk($sformatf("v%0d_busy_end", k),    {63'd0, frm.busy}, 64'd0);
      if (v.exp_busy >= 0)
        chk($sformatf("v%0d_busy_cycles", k), 64'(n_busy), 64'(v.exp_busy));
    end

    // Back-to-back frames: second SOF lands in the srdyi cycle of the first.
    s0 = n_srdyi;
    e0 = n_err;
    exp_q.push_back(mk_frame(21'h11000, 1'b0));
    exp_q.push_back(mk_frame(21'h12000, 1'b0));
    for (int i = 0; i < NUM_CH; i++) send(gen(21'h11000, 1'b0, i), i == 0);
    for (int i = 0; i < NUM_CH; i++) send(gen(21'h12000, 1'b0, i), i == 0);
    idle(4);
    chk("b2b_srdyi_count", 64'(n_srdyi - s0), 64'd2);
    chk("b2b_srdyi_gap",   64'(srdyi_gap),    64'd32);
    chk("b2b_err_pulses",  64'(n_err - e0),   64'd0);

    // Reset in the middle of a frame, after a published frame.
    for (int i = 0; i < 20; i++) send(gen(21'h13000, 1'b0, i), i == 0);
    GlobalReset = 1'b1;
    @(posedge clk); #1;
    GlobalReset = 1'b0;
    exp_cnt = 0;
    s0 = n_srdyi;
    @(negedge clk);
    chk("mid_rst_srdyi",     {63'd0, frm.srdyi},     64'd0);
    chk("mid_rst_busy",      {63'd0, frm.busy},      64'd0);
    chk("mid_rst_err_count", {56'd0, frm.err_count}, 64'd0);
    cmp_frame("mid_rst_x_adc", '0);
    idle(40);
    chk("mid_rst_no_srdyi", 64'(n_srdyi - s0), 64'd0);

    // Orphan flood: error counter saturates.
    e0 = n_err;
    for (int i = 0; i < 300; i++) send(DATA_W'(i), 1'b0);
    idle(2);
    add_err(300);
    chk("sat_err_pulses", 64'(n_err - e0),          64'd300);
    chk("sat_err_count",  {56'd0, frm.err_count},   64'(exp_cnt));
    chk("sat_err_low",    {63'd0, frm.frame_err},   64'd0);
    chk("sat_busy",       {63'd0, frm.busy},        64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()),      64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
